// File: rtl/mem_arbiter_rr_pkg.sv
// Shared types for the round-robin RAM arbiter: FSM encoding, read-tag payload
// and a one-hot decode helper sized for the largest supported core count.
package mem_arbiter_rr_pkg;

   localparam int unsigned MAX_CORES = 16;
   localparam int unsigned CORE_IW   = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } arb_state_e;

   // One entry of the read-return pipeline: which core an issued read belongs to.
   typedef struct packed {
      logic               vld;
      logic [CORE_IW-1:0] idx;
   } rd_tag_t;

   function automatic logic [MAX_CORES-1:0] onehot(input logic [CORE_IW-1:0] idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first requester after start_i (wrapping),
// with start_i itself considered last unless excl_i removes it.
module rr_picker #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] start_i,
   input  logic          excl_i,
   output logic          valid_o,
   output logic [IW-1:0] idx_o
);

   logic [IW-1:0] cand;

   always_comb begin
      valid_o = 1'b0;
      idx_o   = start_i;
      cand    = '0;
      for (int unsigned off = 1; off <= N; off++) begin
         cand = IW'((32'(start_i) + off) % N);
         if (!valid_o && req_i[cand] && !(excl_i && (off == N))) begin
            valid_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter sharing one single-port RAM between NCORES cores, with
// hold limiting, registered RAM strobes and a tagged read-return pipeline.
module mem_arbiter_rr
   import mem_arbiter_rr_pkg::*;
#(
   parameter int unsigned NCORES   = 4,
   parameter int unsigned AW       = 8,
   parameter int unsigned DW       = 8,
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned RD_LAT   = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCORES-1:0]    rden,
   input  logic [NCORES-1:0]    wren,
   input  logic [NCORES*AW-1:0] Address,
   input  logic [NCORES*DW-1:0] Din,
   input  logic [DW-1:0]        ram_q,
   output logic [NCORES-1:0]    acq,
   output logic [DW-1:0]        Dq,
   output logic [NCORES-1:0]    rvalid,
   output logic [AW-1:0]        ram_addr,
   output logic [DW-1:0]        ram_din,
   output logic                 ram_wren,
   output logic                 ram_rden
);

   localparam int unsigned IW = $clog2(NCORES);
   localparam int unsigned HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [HW-1:0] HOLD_MAX   = HW'(MAX_HOLD);
   localparam logic [HW-1:0] HOLD_FIRST = (MAX_HOLD > 0) ? HW'(1) : HW'(0);

   arb_state_e          state_q, state_d;
   logic [IW-1:0]       last_q, last_d;
   logic [HW-1:0]       hold_q, hold_d;
   logic [NCORES-1:0]   req_c, others_c;
   logic                keep_c, grant_c, pick_valid_c;
   logic [IW-1:0]       pick_idx_c, gidx_c;

   logic [NCORES-1:0]   acq_q;
   logic [AW-1:0]       ram_addr_q;
   logic [DW-1:0]       ram_din_q;
   logic                ram_wren_q, ram_rden_q;
   rd_tag_t             pipe_q [RD_LAT];
   rd_tag_t             tail_c;

   assign req_c    = rden | wren;
   assign others_c = req_c & ~NCORES'(onehot(CORE_IW'(last_q)));
   assign keep_c   = req_c[last_q] &&
                     ((MAX_HOLD == 0) || (hold_q < HOLD_MAX) || (others_c == '0));

   // last_q doubles as the owner index while in ST_OWN; the owner is excluded
   // from the search because the picker is only consulted when it must yield.
   rr_picker #(
      .N  (NCORES),
      .IW (IW)
   ) u_picker (
      .req_i   (req_c),
      .start_i (last_q),
      .excl_i  (state_q == ST_OWN),
      .valid_o (pick_valid_c),
      .idx_o   (pick_idx_c)
   );

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      hold_d  = hold_q;
      grant_c = 1'b0;
      gidx_c  = last_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid_c) begin
               grant_c = 1'b1;
               gidx_c  = pick_idx_c;
               state_d = ST_OWN;
               hold_d  = HOLD_FIRST;
            end
         end
         ST_OWN: begin
            if (keep_c) begin
               grant_c = 1'b1;
               if (hold_q < HOLD_MAX) hold_d = hold_q + 1'b1;
            end else if (pick_valid_c) begin
               grant_c = 1'b1;
               gidx_c  = pick_idx_c;
               hold_d  = HOLD_FIRST;
            end else begin
               state_d = ST_IDLE;
               hold_d  = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (grant_c) last_d = gidx_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         last_q  <= IW'(NCORES - 1);
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
      end
   end

   // Issue the granted core's access; address/data hold while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acq_q      <= '0;
         ram_addr_q <= '0;
         ram_din_q  <= '0;
         ram_wren_q <= 1'b0;
         ram_rden_q <= 1'b0;
      end else begin
         acq_q      <= grant_c ? NCORES'(onehot(CORE_IW'(gidx_c))) : '0;
         ram_wren_q <= grant_c & wren[gidx_c];
         ram_rden_q <= grant_c & rden[gidx_c] & ~wren[gidx_c];
         if (grant_c) begin
            ram_addr_q <= Address[gidx_c*AW +: AW];
            ram_din_q  <= Din[gidx_c*DW +: DW];
         end
      end
   end

   // Read tags ride alongside the RAM latency, independent of later grants.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= '{vld: ram_rden_q, idx: CORE_IW'(last_q)};
         for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign tail_c   = pipe_q[RD_LAT-1];
   assign rvalid   = tail_c.vld ? NCORES'(onehot(tail_c.idx)) : '0;
   assign Dq       = ram_q;
   assign acq      = acq_q;
   assign ram_addr = ram_addr_q;
   assign ram_din  = ram_din_q;
   assign ram_wren = ram_wren_q;
   assign ram_rden = ram_rden_q;

endmodule
